snes_pad_controller: RTL and testbench



---
 rtl/pad_defs.sv | 29 ++
 rtl/snes_pad_controller_if.sv | 10 +
 rtl/pad_serial_sampler.sv | 38 +++
 rtl/snes_pad_controller.sv | 149 ++++++++++++++
 tb/tb_snes_pad_controller.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pad_defs.sv
// Shared constants for the SNES pad reader: button bit positions, MMIO word
// selects and the poll sequencer state encoding.
package pad_defs;

  localparam int PAD_BIT_B      = 0;
  localparam int PAD_BIT_Y      = 1;
  localparam int PAD_BIT_SELECT = 2;
  localparam int PAD_BIT_START  = 3;
  localparam int PAD_BIT_UP     = 4;
  localparam int PAD_BIT_DOWN   = 5;
  localparam int PAD_BIT_LEFT   = 6;
  localparam int PAD_BIT_RIGHT  = 7;
  localparam int PAD_BIT_A      = 8;
  localparam int PAD_BIT_X      = 9;
  localparam int PAD_BIT_L      = 10;
  localparam int PAD_BIT_R      = 11;

  localparam logic PAD_ADDR_STATE  = 1'b0;
  localparam logic PAD_ADDR_STATUS = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LATCH   = 3'd1,
    ST_SAMPLE  = 3'd2,
    ST_CLK_LOW = 3'd3,
    ST_DONE    = 3'd4
  } pad_state_t;

endpackage

// File: rtl/snes_pad_controller_if.sv
// CPU-side MMIO read port of the pad reader (pad_en slot, read-only).
interface snes_pad_controller_if;
  logic        cpu_read_en;
  logic        cpu_address;
  logic [31:0] cpu_read_data;
  logic        cpu_read_ready;

  modport master (output cpu_read_en, cpu_address, input cpu_read_data, cpu_read_ready);
  modport slave  (input cpu_read_en, cpu_address, output cpu_read_data, cpu_read_ready);
endinterface

// File: rtl/pad_serial_sampler.sv
// Synchronizes both pad data lines and shifts them, inverted, LSB first into
// one shift register per port.
module pad_serial_sampler #(
  parameter int PAD_BITS = 16
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [1:0]          pad_data,
  input  logic                shift_en,
  output logic [PAD_BITS-1:0] pad0_shift,
  output logic [PAD_BITS-1:0] pad1_shift
);

  logic [1:0] sync_q1;
  logic [1:0] sync_q2;

  // Released lines float high, so the synchronizer resets to "no button".
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q1 <= 2'b11;
      sync_q2 <= 2'b11;
    end else begin
      sync_q1 <= pad_data;
      sync_q2 <= sync_q1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pad0_shift <= '0;
      pad1_shift <= '0;
    end else if (shift_en) begin
      pad0_shift <= {~sync_q2[0], pad0_shift[PAD_BITS-1:1]};
      pad1_shift <= {~sync_q2[1], pad1_shift[PAD_BITS-1:1]};
    end
  end

endmodule

// File: rtl/snes_pad_controller.sv
// Two-port SNES gamepad reader: sequences latch/clock, samples both pads and
// publishes both states atomically to the CPU.
//
// state    | meaning
// IDLE     | lines idle, waiting for poll_start
// LATCH    | pad_latch high for 2*HALF_PERIOD cycles
// SAMPLE   | pad_clk high; last cycle shifts one bit per pad
// CLK_LOW  | pad_clk low for HALF_PERIOD cycles
// DONE     | publish both shift registers, set valid
module snes_pad_controller
  import pad_defs::*;
#(
  parameter int HALF_PERIOD = 200,
  parameter int PAD_BITS    = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  poll_start,
  output logic                  pad_latch,
  output logic                  pad_clk,
  input  logic [1:0]            pad_data,
  output logic                  busy,
  snes_pad_controller_if.slave  cpu
);

  localparam int CNT_W = $clog2(2 * HALF_PERIOD);
  localparam int IDX_W = $clog2(PAD_BITS);
  localparam logic [CNT_W-1:0] LATCH_LOAD = CNT_W'(2 * HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0] HALF_LOAD  = CNT_W'(HALF_PERIOD - 1);
  localparam logic [IDX_W-1:0] LAST_BIT   = IDX_W'(PAD_BITS - 1);

  pad_state_t          state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [IDX_W-1:0]    bit_idx, bit_idx_nxt;
  logic                shift_en;
  logic [PAD_BITS-1:0] pad0_shift, pad1_shift;
  logic [PAD_BITS-1:0] pad0_state, pad1_state;
  logic                valid;
  logic [31:0]         state_word;

  pad_serial_sampler #(.PAD_BITS(PAD_BITS)) u_sampler (
    .clk        (clk),
    .resetn     (resetn),
    .pad_data   (pad_data),
    .shift_en   (shift_en),
    .pad0_shift (pad0_shift),
    .pad1_shift (pad1_shift)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_idx_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_idx_nxt = bit_idx;
    shift_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (poll_start) begin
          state_nxt   = ST_LATCH;
          cnt_nxt     = LATCH_LOAD;
          bit_idx_nxt = '0;
        end
      end
      ST_LATCH: begin
        if (cnt == '0) begin
          state_nxt = ST_SAMPLE;
          cnt_nxt   = HALF_LOAD;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      ST_SAMPLE: begin
        if (cnt == '0) begin
          shift_en = 1'b1;
          if (bit_idx < LAST_BIT) begin
            state_nxt   = ST_CLK_LOW;
            cnt_nxt     = HALF_LOAD;
            bit_idx_nxt = bit_idx + 1'b1;
          end else begin
            state_nxt = ST_DONE;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      ST_CLK_LOW: begin
        if (cnt == '0) begin
          state_nxt = ST_SAMPLE;
          cnt_nxt   = HALF_LOAD;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Decoded straight from the state register so reset idles the lines at once.
  assign pad_latch = (state == ST_LATCH);
  assign pad_clk   = (state != ST_CLK_LOW);
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pad0_state <= '0;
      pad1_state <= '0;
      valid      <= 1'b0;
    end else begin
      if (state == ST_DONE) begin
        pad0_state <= pad0_shift;
        pad1_state <= pad1_shift;
        valid      <= 1'b1;
      end else if (cpu.cpu_read_en && cpu.cpu_address == PAD_ADDR_STATE) begin
        valid <= 1'b0;
      end
    end
  end

  // A read landing on DONE returns the data being published in that cycle.
  assign state_word = (state == ST_DONE) ? 32'({pad1_shift, pad0_shift})
                                         : 32'({pad1_state, pad0_state});

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cpu.cpu_read_ready <= 1'b0;
      cpu.cpu_read_data  <= '0;
    end else if (cpu.cpu_read_en) begin
      cpu.cpu_read_ready <= 1'b1;
      cpu.cpu_read_data  <= (cpu.cpu_address == PAD_ADDR_STATUS) ? {30'b0, busy, valid}
                                                                  : state_word;
    end else begin
      cpu.cpu_read_ready <= 1'b0;
      cpu.cpu_read_data  <= '0;
    end
  end

endmodule

// File: tb/tb_snes_pad_controller.sv
// Bench for snes_pad_controller: behavioural pad models on both ports, a
// vector table of full polls, and directed multi-cycle corner sequences.
module tb_snes_pad_controller;

  localparam int HP       = 4;
  localparam int BUSY_LEN = 33 * HP + 1;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       poll_start = 1'b0;
  logic       pad_latch;
  logic       pad_clk;
  logic       busy;
  logic [1:0] pad_data;

  snes_pad_controller_if cpu_bus();

  snes_pad_controller #(.HALF_PERIOD(HP), .PAD_BITS(16)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .poll_start (poll_start),
    .pad_latch  (pad_latch),
    .pad_clk    (pad_clk),
    .pad_data   (pad_data),
    .busy       (busy),
    .cpu        (cpu_bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Pad model: latch reloads bit 0, each rising pad_clk advances one bit.
  logic [15:0] pad0_val = 16'h0000;
  logic [15:0] pad1_val = 16'h0000;
  logic [4:0]  bit_idx = 5'd0;
  logic        pad_clk_q = 1'b1;

  always @(posedge clk) begin
    if (pad_latch) bit_idx <= 5'd0;
    else if (pad_clk && !pad_clk_q && bit_idx < 5'd16) bit_idx <= bit_idx + 5'd1;
    pad_clk_q <= pad_clk;
  end

  assign pad_data = {~pad1_val[bit_idx[3:0]], ~pad0_val[bit_idx[3:0]]};

  // Line monitor, sampled mid-cycle.
  int   busy_cyc = 0, latch_cyc = 0, latch_rise = 0, low_cyc = 0, low_fall = 0, overlap = 0;
  logic latch_mq = 1'b0;
  logic clk_mq = 1'b1;

  always @(negedge clk) begin
    if (busy) busy_cyc++;
    if (pad_latch) latch_cyc++;
    if (!pad_clk) low_cyc++;
    if (pad_latch && !latch_mq) latch_rise++;
    if (!pad_clk && clk_mq) low_fall++;
    if (pad_latch && !pad_clk) overlap++;
    latch_mq = pad_latch;
    clk_mq   = pad_clk;
  end

  typedef struct {
    logic [15:0] p0;
    logic [15:0] p1;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic start_poll();
    @(negedge clk);
    poll_start = 1'b1;
    @(negedge clk);
    poll_start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle", 32'(busy), 32'd0);
  endtask

  // Call at a negedge; returns the registered response one cycle later.
  task automatic cpu_read(input logic addr, output logic [31:0] data);
    cpu_bus.cpu_read_en = 1'b1;
    cpu_bus.cpu_address = addr;
    @(negedge clk);
    check("read_ready", 32'(cpu_bus.cpu_read_ready), 32'd1);
    data = cpu_bus.cpu_read_data;
    cpu_bus.cpu_read_en = 1'b0;
    @(negedge clk);
    check("ready_drop", 32'(cpu_bus.cpu_read_ready), 32'd0);
    check("data_idle", cpu_bus.cpu_read_data, 32'd0);
  endtask

  task automatic poll_and_check(input string tag, input logic [15:0] p0,
                                input logic [15:0] p1, input logic [31:0] exp_word);
    int b0, l0, lr0, lc0, lf0;
    logic [31:0] d;
    pad0_val = p0;
    pad1_val = p1;
    b0 = busy_cyc; l0 = latch_cyc; lr0 = latch_rise; lc0 = low_cyc; lf0 = low_fall;
    start_poll();
    wait_idle();
    check({tag, "_busy_len"},   32'(busy_cyc - b0),   32'(BUSY_LEN));
    check({tag, "_latch_len"},  32'(latch_cyc - l0),  32'(2 * HP));
    check({tag, "_latch_cnt"},  32'(latch_rise - lr0), 32'd1);
    check({tag, "_low_pulses"}, 32'(low_fall - lf0),  32'd15);
    check({tag, "_low_cycles"}, 32'(low_cyc - lc0),   32'(15 * HP));
    cpu_read(1'b1, d);
    check({tag, "_status_pre"}, d, 32'h0000_0001);
    cpu_read(1'b0, d);
    check({tag, "_state"}, d, exp_word);
    cpu_read(1'b1, d);
    check({tag, "_status_post"}, d, 32'h0000_0000);
  endtask

  initial begin
    logic [31:0] d;
    int b0, lr0;

    vecs[0] = '{p0: 16'h0F0F, p1: 16'h8001, exp_word: 32'h8001_0F0F};
    vecs[1] = '{p0: 16'hFFFF, p1: 16'hFFFF, exp_word: 32'hFFFF_FFFF};
    vecs[2] = '{p0: 16'h0000, p1: 16'h0000, exp_word: 32'h0000_0000};
    vecs[3] = '{p0: 16'h1234, p1: 16'hA5C3, exp_word: 32'hA5C3_1234};

    cpu_bus.cpu_read_en = 1'b0;
    cpu_bus.cpu_address = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_latch", 32'(pad_latch), 32'd0);
    check("rst_clk",   32'(pad_clk),   32'd1);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_ready", 32'(cpu_bus.cpu_read_ready), 32'd0);
    check("rst_data",  cpu_bus.cpu_read_data, 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    cpu_read(1'b1, d);
    check("rst_status", d, 32'd0);
    cpu_read(1'b0, d);
    check("rst_state", d, 32'd0);

    for (int i = 0; i < 4; i++)
      poll_and_check($sformatf("vec%0d", i), vecs[i].p0, vecs[i].p1, vecs[i].exp_word);

    // Second poll_start mid-sequence is dropped.
    pad0_val = 16'h0F0F;
    pad1_val = 16'h8001;
    b0 = busy_cyc; lr0 = latch_rise;
    start_poll();
    repeat (19) @(negedge clk);
    poll_start = 1'b1;
    @(negedge clk);
    poll_start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    check("ign_busy_len",  32'(busy_cyc - b0),   32'(BUSY_LEN));
    check("ign_latch_cnt", 32'(latch_rise - lr0), 32'd1);
    cpu_read(1'b0, d);
    check("ign_state", d, 32'h8001_0F0F);

    // Mid-poll read returns the previous completed states.
    pad0_val = 16'hFFFF;
    pad1_val = 16'hFFFF;
    start_poll();
    repeat (59) @(negedge clk);
    check("mid_busy", 32'(busy), 32'd1);
    cpu_read(1'b0, d);
    check("mid_state_old", d, 32'h8001_0F0F);
    wait_idle();
    cpu_read(1'b0, d);
    check("mid_state_new", d, 32'hFFFF_FFFF);

    // Address-0 read in the DONE cycle: new data returned, valid survives.
    pad0_val = 16'h1234;
    pad1_val = 16'hA5C3;
    start_poll();
    repeat (BUSY_LEN - 1) @(negedge clk);
    check("done_busy", 32'(busy), 32'd1);
    cpu_read(1'b0, d);
    check("done_state", d, 32'hA5C3_1234);
    check("done_idle", 32'(busy), 32'd0);
    cpu_read(1'b1, d);
    check("done_valid_kept", d, 32'h0000_0001);

    // Reset mid-poll, during a clock-low phase.
    pad0_val = 16'h5555;
    pad1_val = 16'hAAAA;
    start_poll();
    repeat (52) @(negedge clk);
    check("pre_rst_clk_low", 32'(pad_clk), 32'd0);
    #2 resetn = 1'b0;
    #1;
    check("arst_latch", 32'(pad_latch), 32'd0);
    check("arst_clk",   32'(pad_clk),   32'd1);
    check("arst_busy",  32'(busy),      32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    cpu_read(1'b0, d);
    check("arst_state", d, 32'd0);
    cpu_read(1'b1, d);
    check("arst_status", d, 32'd0);
    poll_and_check("post_rst", 16'h5555, 16'hAAAA, 32'hAAAA_5555);

    // Released pads, then back-to-back reads: state followed by status.
    pad0_val = 16'h0000;
    pad1_val = 16'h0000;
    pad1_val = 16'h0000;
    start_poll();
    wait_idle();
    check("rel_lines", 32'(pad_data), 32'd3);
    cpu_read(1'b1, d);
    check("rel_status_pre", d, 32'h0000_0001);
    cpu_bus.cpu_read_en = 1'b1;
    cpu_bus.cpu_address = 1'b0;
    @(negedge clk);
    check("b2b_ready0", 32'(cpu_bus.cpu_read_ready), 32'd1);
    check("b2b_state",  cpu_bus.cpu_read_data, 32'h0000_0000);
    cpu_bus.cpu_address = 1'b1;
    @(negedge clk);
    check("b2b_ready1", 32'(cpu_bus.cpu_read_ready), 32'd1);
    check("b2b_status", cpu_bus.cpu_read_data, 32'h0000_0000);
    cpu_bus.cpu_read_en = 1'b0;
    @(negedge clk);
    check("b2b_ready_drop", 32'(cpu_bus.cpu_read_ready), 32'd0);

    check("latch_clk_overlap", 32'(overlap), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: sim time %0t exceeded limit", $time);
    $fatal(1);
  end

endmodule
